// File: rtl/iccm_arb_pkg.sv
// Shared defaults, response error codes, FSM states and grant priority type
// for the ICCM port arbiter.
package iccm_arb_pkg;

    localparam int unsigned CORE_AW_DEF = 14;
    localparam int unsigned MEM_AW_DEF  = 8;
    localparam int unsigned DW_DEF      = 32;

    localparam logic [1:0] RERR_NONE  = 2'b00;
    localparam logic [1:0] RERR_RANGE = 2'b01;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } arb_state_e;

    typedef enum logic {
        PRIO_LOADER,
        PRIO_CORE
    } prio_e;

endpackage

// File: rtl/iccm_arb_rr2.sv
// Two-requester grant select (loader vs core); prio_i picks the winner on
// contention, otherwise the sole requester is granted.
module iccm_arb_rr2
    import iccm_arb_pkg::*;
(
    input  logic  req_ldr_i,
    input  logic  req_core_i,
    input  prio_e prio_i,
    output logic  gnt_ldr_o,
    output logic  gnt_core_o
);

    always_comb begin
        gnt_ldr_o  = req_ldr_i  & ~(req_core_i & (prio_i == PRIO_CORE));
        gnt_core_o = req_core_i & ~(req_ldr_i  & (prio_i == PRIO_LOADER));
    end

endmodule

// File: rtl/iccm_port_arbiter.sv
// Arbitrates core and loader accesses onto a single OpenRAM port.
// Define ICCM_ARB_FAIRNESS_EN to alternate grants on contention (default: loader priority).
module iccm_port_arbiter
    import iccm_arb_pkg::*;
#(
    parameter int unsigned CORE_AW = CORE_AW_DEF,
    parameter int unsigned MEM_AW  = MEM_AW_DEF,
    parameter int unsigned DW      = DW_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               core_req_i,
    input  logic               core_we_i,
    input  logic [CORE_AW-1:0] core_addr_i,
    input  logic [DW-1:0]      core_wdata_i,
    input  logic [DW-1:0]      core_wmask_i,
    output logic               core_gnt_o,
    output logic               core_rvalid_o,
    output logic [DW-1:0]      core_rdata_o,
    output logic [1:0]         core_rerror_o,
    input  logic               prog_we_i,
    input  logic [CORE_AW-1:0] prog_addr_i,
    input  logic [DW-1:0]      prog_wdata_i,
    output logic               prog_busy_o,
    output logic               prog_overrun_o,
    output logic               mem_csb_o,
    output logic               mem_web_o,
    output logic [DW/8-1:0]    mem_wmask_o,
    output logic [MEM_AW-1:0]  mem_addr_o,
    output logic [DW-1:0]      mem_din_o,
    input  logic [DW-1:0]      mem_dout_i
);

    localparam int unsigned NB = DW / 8;

    arb_state_e        state_q, state_d;
    logic              resp_err_q, resp_err_d;
    logic              buf_valid_q, buf_valid_d;
    logic [MEM_AW-1:0] buf_addr_q, buf_addr_d;
    logic [DW-1:0]     buf_data_q, buf_data_d;
    logic              overrun_q, overrun_d;

    logic              prog_in_range, prog_ok, core_in_range;
    logic              ldr_req, core_mem_req, gnt_ldr, gnt_core_mem, core_gnt;
    logic [MEM_AW-1:0] ldr_addr;
    logic [DW-1:0]     ldr_data;
    logic [NB-1:0]     core_bmask;
    prio_e             prio;

    // An incoming loader write bypasses the empty buffer so it can issue at once.
    always_comb begin
        prog_in_range = (prog_addr_i[CORE_AW-1:MEM_AW] == '0);
        core_in_range = (core_addr_i[CORE_AW-1:MEM_AW] == '0);
        prog_ok       = prog_we_i & prog_in_range;
        ldr_req       = buf_valid_q | prog_ok;
        core_mem_req  = core_req_i & core_in_range;
        ldr_addr      = buf_valid_q ? buf_addr_q : prog_addr_i[MEM_AW-1:0];
        ldr_data      = buf_valid_q ? buf_data_q : prog_wdata_i;
        for (int unsigned i = 0; i < NB; i++) begin
            core_bmask[i] = |core_wmask_i[8*i +: 8];
        end
    end

`ifdef ICCM_ARB_FAIRNESS_EN
    prio_e prio_q, prio_d;

    always_comb begin
        prio_d = prio_q;
        if (ldr_req && core_mem_req) begin
            prio_d = (prio_q == PRIO_CORE) ? PRIO_LOADER : PRIO_CORE;
        end
        prio = prio_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) prio_q <= PRIO_CORE;
        else         prio_q <= prio_d;
    end
`else
    always_comb prio = PRIO_LOADER;
`endif

    iccm_arb_rr2 u_rr2 (
        .req_ldr_i  (ldr_req),
        .req_core_i (core_mem_req),
        .prio_i     (prio),
        .gnt_ldr_o  (gnt_ldr),
        .gnt_core_o (gnt_core_mem)
    );

    always_comb begin
        core_gnt    = core_req_i & (~core_in_range | gnt_core_mem);
        state_d     = (core_gnt && !core_we_i) ? ST_RESP : ST_IDLE;
        resp_err_d  = ~core_in_range;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        if (buf_valid_q && gnt_ldr) buf_valid_d = 1'b0;
        // Store the new write when the buffer drains this cycle, or when it was empty and lost arbitration.
        if (prog_ok && (buf_valid_q == gnt_ldr)) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = prog_addr_i[MEM_AW-1:0];
            buf_data_d  = prog_wdata_i;
        end
        overrun_d = overrun_q | (prog_we_i & (~prog_in_range | (buf_valid_q & ~gnt_ldr)));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            resp_err_q  <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            resp_err_q  <= resp_err_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        mem_csb_o   = 1'b1;
        mem_web_o   = 1'b1;
        mem_wmask_o = '0;
        mem_addr_o  = '0;
        mem_din_o   = '0;
        if (rst_ni) begin
            if (gnt_ldr) begin
                mem_csb_o   = 1'b0;
                mem_web_o   = 1'b0;
                mem_wmask_o = '1;
                mem_addr_o  = ldr_addr;
                mem_din_o   = ldr_data;
            end else if (gnt_core_mem) begin
                mem_csb_o  = 1'b0;
                mem_addr_o = core_addr_i[MEM_AW-1:0];
                if (core_we_i) begin
                    mem_web_o   = 1'b0;
                    mem_wmask_o = core_bmask;
                    mem_din_o   = core_wdata_i;
                end
            end
        end
        core_gnt_o     = rst_ni & core_gnt;
        core_rvalid_o  = (state_q == ST_RESP);
        core_rdata_o   = (core_rvalid_o && !resp_err_q) ? mem_dout_i : '0;
        core_rerror_o  = (core_rvalid_o && resp_err_q) ? RERR_RANGE : RERR_NONE;
        prog_busy_o    = buf_valid_q;
        prog_overrun_o = overrun_q;
    end

endmodule

// File: tb/tb_iccm_port_arbiter.sv
// Self-checking bench for iccm_port_arbiter: behavioural SRAM harness plus a
// transaction-level reference model of the arbiter, directed and random stimulus.
module tb_iccm_port_arbiter;

    localparam int unsigned CAW = 14;
    localparam int unsigned MAW = 8;
    localparam int unsigned DW  = 32;
    localparam logic [83:0] RST_V = {38'd0, 2'b11, 44'd0};

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            core_req, core_we;
    logic [CAW-1:0]  core_addr;
    logic [DW-1:0]   core_wdata, core_wmask;
    logic            core_gnt_o, core_rvalid_o;
    logic [DW-1:0]   core_rdata_o;
    logic [1:0]      core_rerror_o;
    logic            prog_we;
    logic [CAW-1:0]  prog_addr;
    logic [DW-1:0]   prog_wdata;
    logic            prog_busy_o, prog_overrun_o;
    logic            mem_csb_o, mem_web_o;
    logic [3:0]      mem_wmask_o;
    logic [MAW-1:0]  mem_addr_o;
    logic [DW-1:0]   mem_din_o, sram_dout;
    logic [83:0]     obs, exp_v;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    iccm_port_arbiter #(.CORE_AW(CAW), .MEM_AW(MAW), .DW(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
        .core_wdata_i(core_wdata), .core_wmask_i(core_wmask), .core_gnt_o(core_gnt_o),
        .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o), .core_rerror_o(core_rerror_o),
        .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_wdata_i(prog_wdata),
        .prog_busy_o(prog_busy_o), .prog_overrun_o(prog_overrun_o),
        .mem_csb_o(mem_csb_o), .mem_web_o(mem_web_o), .mem_wmask_o(mem_wmask_o),
        .mem_addr_o(mem_addr_o), .mem_din_o(mem_din_o), .mem_dout_i(sram_dout)
    );

    always #5 clk_i = ~clk_i;

    // Byte-masked synchronous SRAM standing in for the OpenRAM macro.
    logic [DW-1:0] sram [256];
    always @(posedge clk_i) begin
        if (!mem_csb_o) begin
            if (!mem_web_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_din_o[8*b +: 8];
            end else begin
                sram_dout <= sram[mem_addr_o];
            end
        end
    end

    always_comb obs = {core_gnt_o, core_rvalid_o, core_rdata_o, core_rerror_o, prog_busy_o,
                       prog_overrun_o, mem_csb_o, mem_web_o, mem_wmask_o, mem_addr_o, mem_din_o};

    // ---------------- reference model ----------------
    logic          m_buf_v, m_ovr, m_turn_core, m_pend, m_perr;
    logic [7:0]    m_buf_a;
    logic [31:0]   m_buf_d, m_pdata;
    logic [31:0]   ref_mem [256];
    logic          e_gnt, e_ldr, e_core, e_in_ok, e_contend;
    logic [3:0]    e_wm;
    logic [7:0]    e_ad;
    logic [31:0]   e_di;

    task automatic model_reset();
        m_buf_v = 0; m_ovr = 0; m_turn_core = 1; m_pend = 0; m_perr = 0; m_pdata = 0;
    endtask

    task automatic model_eval();
        logic core_mem, ldr_wants, csb, web;
        logic [3:0] bm;
        e_in_ok   = prog_we && (prog_addr < 14'd256);
        core_mem  = core_req && (core_addr < 14'd256);
        ldr_wants = m_buf_v || e_in_ok;
        e_contend = ldr_wants && core_mem;
`ifdef ICCM_ARB_FAIRNESS_EN
        e_ldr = ldr_wants && !(e_contend && m_turn_core);
`else
        e_ldr = ldr_wants;
`endif
        e_core = core_mem && !e_ldr;
        e_gnt  = core_req && ((core_addr >= 14'd256) || e_core);
        for (int b = 0; b < 4; b++) bm[b] = (core_wmask[8*b +: 8] != 8'h00);
        csb = 1; web = 1; e_wm = 0; e_ad = 0; e_di = 0;
        if (e_ldr) begin
            csb = 0; web = 0; e_wm = 4'hF;
            e_ad = m_buf_v ? m_buf_a : prog_addr[7:0];
            e_di = m_buf_v ? m_buf_d : prog_wdata;
        end else if (e_core) begin
            csb = 0; e_ad = core_addr[7:0];
            if (core_we) begin web = 0; e_wm = bm; e_di = core_wdata; end
        end
        exp_v = {e_gnt, m_pend, (m_pend && !m_perr) ? m_pdata : 32'd0,
                 (m_pend && m_perr) ? 2'b01 : 2'b00, m_buf_v, m_ovr, csb, web, e_wm, e_ad, e_di};
    endtask

    task automatic model_commit();
        m_pend  = e_gnt && !core_we;
        m_perr  = core_addr >= 14'd256;
        m_pdata = (m_pend && !m_perr) ? ref_mem[core_addr[7:0]] : 32'd0;
        if (e_ldr || (e_core && core_we))
            for (int b = 0; b < 4; b++)
                if (e_wm[b]) ref_mem[e_ad][8*b +: 8] = e_di[8*b +: 8];
        if (e_ldr && m_buf_v) begin
            m_buf_v = e_in_ok;
            if (e_in_ok) begin m_buf_a = prog_addr[7:0]; m_buf_d = prog_wdata; end
        end else if (!e_ldr && e_in_ok) begin
            if (m_buf_v) m_ovr = 1;
            else begin m_buf_v = 1; m_buf_a = prog_addr[7:0]; m_buf_d = prog_wdata; end
        end
        if (prog_we && prog_addr >= 14'd256) m_ovr = 1;
        if (e_contend) m_turn_core = !m_turn_core;
    endtask

    task automatic idle_inputs();
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0; core_wmask = 0;
        prog_we = 0; prog_addr = 0; prog_wdata = 0;
    endtask

    task automatic tick();
        @(posedge clk_i); model_commit(); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_ni = 0;
        for (int i = 0; i < 3; i++) begin
            core_req = 1'($urandom); core_we = 1'($urandom); core_addr = 14'($urandom);
            prog_we = 1'($urandom); prog_addr = 14'($urandom); prog_wdata = $urandom;
            @(negedge clk_i);
            n_checks++;
            if (obs !== RST_V) begin n_fail++; $display("FAIL reset_hold: got %h want %h", obs, RST_V); end
            @(posedge clk_i); #1;
        end
        idle_inputs(); rst_ni = 1; model_reset();
        @(negedge clk_i); model_eval();
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_release: got %h want %h", obs, exp_v); end
        tick();
    endtask

    task automatic test_preload();
        for (int i = 0; i < 32; i++) begin
            prog_we = 1; prog_addr = 14'(i); prog_wdata = $urandom;
            @(negedge clk_i); model_eval();
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL preload[%0d]: got %h want %h", i, obs, exp_v); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_core_read();
        core_req = 1; core_addr = 14'h005;
        @(negedge clk_i); model_eval();
        n_checks++;
        if ({core_gnt_o, mem_csb_o, mem_web_o, mem_addr_o} !== {3'b101, 8'h05}) begin
            n_fail++; $display("FAIL core_read_issue: got %b%b%b %h want 101 05", core_gnt_o, mem_csb_o, mem_web_o, mem_addr_o);
        end
        tick(); idle_inputs();
        @(negedge clk_i); model_eval();
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL core_read_resp: got %h want %h", obs, exp_v); end
        tick();
    endtask

    task automatic test_loader_vs_core();
        prog_we = 1; prog_addr = 14'h00A; prog_wdata = 32'hDEADBEEF;
        core_req = 1; core_addr = 14'h00A;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i); model_eval();
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL ldr_vs_core c%0d: got %h want %h", c, obs, exp_v); end
`ifndef ICCM_ARB_FAIRNESS_EN
            if (c == 0) begin
                n_checks++;
                if ({core_gnt_o, mem_web_o, mem_wmask_o} !== 6'b0_0_1111) begin
                    n_fail++; $display("FAIL ldr_first: got gnt=%b web=%b wm=%h want 0 0 f", core_gnt_o, mem_web_o, mem_wmask_o);
                end
            end
            if (c == 2) begin
                n_checks++;
                if ({core_rvalid_o, core_rdata_o} !== {1'b1, 32'hDEADBEEF}) begin
                    n_fail++; $display("FAIL ldr_then_read: got %b %h want 1 deadbeef", core_rvalid_o, core_rdata_o);
                end
            end
`endif
            tick();
            if (c == 0) prog_we = 0;
            if (e_gnt) core_req = 0;
        end
        idle_inputs();
    endtask

    task automatic test_core_write();
        core_req = 1; core_we = 1; core_addr = 14'h003; core_wdata = $urandom; core_wmask = 32'h0000FF00;
        @(negedge clk_i); model_eval();
        n_checks++;
        if ({mem_wmask_o, mem_web_o, mem_csb_o, core_gnt_o} !== 7'b0010_0_0_1) begin
            n_fail++; $display("FAIL core_write: got wm=%b web=%b csb=%b gnt=%b want 0010 0 0 1", mem_wmask_o, mem_web_o, mem_csb_o, core_gnt_o);
        end
        tick();
        core_we = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i); model_eval();
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL write_readback c%0d: got %h want %h", c, obs, exp_v); end
            tick(); idle_inputs();
        end
    endtask

    task automatic test_back_to_back();
        core_req = 1; core_addr = 14'h001;
        for (int c = 0; c < 6; c++) begin
            prog_we = (c < 2); prog_addr = 14'(16 + c); prog_wdata = $urandom;
            @(negedge clk_i); model_eval();
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL back_to_back c%0d: got %h want %h", c, obs, exp_v); end
            tick();
            if (e_gnt) core_addr = 14'(c + 2);
        end
        n_checks++;
        if (prog_overrun_o !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b want 0", prog_overrun_o); end
        idle_inputs();
    endtask

    task automatic test_out_of_range();
        core_req = 1; core_addr = 14'h100;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i); model_eval();
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL oor_read c%0d: got %h want %h", c, obs, exp_v); end
            if (c == 1) begin
                n_checks++;
                if ({core_rvalid_o, core_rerror_o, core_rdata_o} !== {1'b1, 2'b01, 32'd0}) begin
                    n_fail++; $display("FAIL oor_rerror: got %b %b %h want 1 01 0", core_rvalid_o, core_rerror_o, core_rdata_o);
                end
            end
            tick();
            core_we = 1; core_addr = 14'h123; core_wmask = '1;
            if (c == 1) idle_inputs();
        end
        prog_we = 1; prog_addr = 14'h2000; prog_wdata = $urandom;
        @(negedge clk_i); model_eval();
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL oor_prog: got %h want %h", obs, exp_v); end
        tick(); idle_inputs();
        n_checks++;
        if ({prog_overrun_o, prog_busy_o, mem_csb_o} !== 3'b101) begin
            n_fail++; $display("FAIL oor_prog_sticky: got %b%b%b want 101", prog_overrun_o, prog_busy_o, mem_csb_o);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if (!(core_req && !e_gnt)) begin
                core_req = ($urandom_range(0, 99) < 60);
                core_we = 1'($urandom);
                core_addr = ($urandom_range(0, 19) == 0) ? 14'(256 + $urandom_range(0, 999)) : 14'($urandom_range(0, 31));
                core_wdata = $urandom;
                for (int b = 0; b < 4; b++) core_wmask[8*b +: 8] = 1'($urandom) ? 8'($urandom) : 8'h00;
            end
            prog_we = ($urandom_range(0, 99) < 30);
            prog_addr = ($urandom_range(0, 29) == 0) ? 14'h3F00 : 14'($urandom_range(0, 31));
            prog_wdata = $urandom;
            @(negedge clk_i); model_eval();
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL random c%0d: got %h want %h", c, obs, exp_v); end
            tick();
        end
        idle_inputs();
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_resp();
        core_req = 1; core_addr = 14'h007;
        @(negedge clk_i); model_eval();
        tick(); idle_inputs();
        #1 rst_ni = 0;
        #1;
        n_checks++;
        if (obs !== RST_V) begin n_fail++; $display("FAIL reset_mid_resp: got %h want %h", obs, RST_V); end
        @(posedge clk_i); #1;
        rst_ni = 1; model_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i); model_eval();
            n_checks++;
            if (obs !== exp_v || core_rvalid_o !== 1'b0) begin
                n_fail++; $display("FAIL post_reset c%0d: got %h want %h", c, obs, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        e_gnt = 0;
        test_reset();
        test_preload();
        test_core_read();
        test_loader_vs_core();
        test_core_write();
        test_back_to_back();
        test_out_of_range();
        test_random();
        test_reset_mid_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
